// File: rtl/bsg_wormhole_inject_arbiter_pkg.sv
// Shared types and helpers for the wormhole injection arbiter.
// Holds the packet FSM state encoding and the round-robin wrap helper.
package bsg_wormhole_inject_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_e;

    // Next requester index after id, wrapping at n.
    function automatic int wrap_inc(int id, int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/bsg_wormhole_inject_arbiter_two_fifo.sv
// Two-entry ready/valid buffer giving full throughput with registered valid.
// Ports: data_i/v_i/ready_o enqueue side, data_o/v_o/yumi_i dequeue side.
module bsg_wormhole_inject_arbiter_two_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         cnt_r;
    logic               enq;
    logic               deq;

    assign ready_o = (cnt_r != 2'd2);
    assign v_o     = (cnt_r != 2'd0);
    assign data_o  = mem_r[rptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r <= 1'b0;
            rptr_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            cnt_r <= cnt_r + 2'(enq) - 2'(deq);
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_r.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_wormhole_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one router injection port.
// Ports: req_* per requester, link_* to router, grant_id_o/locked_o status.
module bsg_wormhole_inject_arbiter
    import bsg_wormhole_inject_arbiter_pkg::*;
#(
    parameter int flit_width_p = 32,
    parameter int len_width_p  = 4,
    parameter int len_pos_p    = 8,
    parameter int num_req_p    = 4,
    localparam int id_width_lp = $clog2(num_req_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_req_p-1:0][flit_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    output logic [num_req_p-1:0]                  req_ready_and_o,
    output logic [flit_width_p-1:0]               link_data_o,
    output logic                                  link_v_o,
    input  logic                                  link_ready_and_i,
    output logic [id_width_lp-1:0]                grant_id_o,
    output logic                                  locked_o
);

    state_e                  state_r, state_n;
    logic [id_width_lp-1:0]  rr_ptr_r, rr_ptr_n;
    logic [id_width_lp-1:0]  lock_id_r, lock_id_n;
    logic [len_width_p-1:0]  count_r, count_n;
    logic [id_width_lp-1:0]  winner;
    logic [id_width_lp-1:0]  sel_id;
    logic [id_width_lp:0]    idx_sum;
    logic                    found;
    logic [flit_width_p-1:0] sel_data;
    logic                    sel_v;
    logic                    fifo_ready;
    logic                    arb_ready;
    logic                    accept;
    logic [len_width_p-1:0]  hdr_len;

    // Rotate-priority search starting at rr_ptr_r.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < num_req_p; i++) begin
            idx_sum = {1'b0, rr_ptr_r} + (id_width_lp+1)'(i);
            if (idx_sum >= (id_width_lp+1)'(num_req_p))
                idx_sum = idx_sum - (id_width_lp+1)'(num_req_p);
            if (!found && req_v_i[idx_sum[id_width_lp-1:0]]) begin
                found  = 1'b1;
                winner = idx_sum[id_width_lp-1:0];
            end
        end
    end

    assign sel_id    = (state_r == BODY) ? lock_id_r : winner;
    assign sel_data  = req_data_i[sel_id];
    assign sel_v     = req_v_i[sel_id];
    // Reset forces ready low combinationally, not just at the next edge.
    assign arb_ready = fifo_ready & ~reset_i;
    assign accept    = sel_v & arb_ready;
    assign hdr_len   = sel_data[len_pos_p +: len_width_p];

    always_comb begin
        req_ready_and_o = '0;
        if (state_r == BODY || found)
            req_ready_and_o[sel_id] = arb_ready;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            lock_id_r <= '0;
            count_r   <= '0;
        end else begin
            state_r   <= state_n;
            rr_ptr_r  <= rr_ptr_n;
            lock_id_r <= lock_id_n;
            count_r   <= count_n;
        end
    end

    always_comb begin
        state_n   = state_r;
        rr_ptr_n  = rr_ptr_r;
        lock_id_n = lock_id_r;
        count_n   = count_r;
        unique case (state_r)
            IDLE: begin
                if (accept) begin
                    if (hdr_len == '0) begin
                        rr_ptr_n = id_width_lp'(
                            wrap_inc(int'(winner), num_req_p));
                    end else begin
                        state_n   = BODY;
                        lock_id_n = winner;
                        count_n   = hdr_len;
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    count_n = count_r - len_width_p'(1);
                    // Exit at count 1 so count never wraps.
                    if (count_r == len_width_p'(1)) begin
                        state_n  = IDLE;
                        rr_ptr_n = id_width_lp'(
                            wrap_inc(int'(lock_id_r), num_req_p));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign grant_id_o = sel_id;
    assign locked_o   = (state_r == BODY);

    bsg_wormhole_inject_arbiter_two_fifo #(
        .width_p (flit_width_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (sel_data),
        .v_i     (accept),
        .ready_o (fifo_ready),
        .data_o  (link_data_o),
        .v_o     (link_v_o),
        .yumi_i  (link_v_o & link_ready_and_i)
    );

endmodule

// File: tb/tb_bsg_wormhole_inject_arbiter.sv
// Directed self-checking bench for bsg_wormhole_inject_arbiter.
// Drives per-requester flit queues and logs link traffic for comparison.
module tb_bsg_wormhole_inject_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [N-1:0][W-1:0] req_data_i;
    logic [N-1:0]        req_v_i;
    logic [N-1:0]        req_ready_and_o;
    logic [W-1:0]        link_data_o;
    logic                link_v_o;
    logic                link_ready_and_i;
    logic [1:0]          grant_id_o;
    logic                locked_o;

    always #5 clk = ~clk;

    bsg_wormhole_inject_arbiter #(
        .flit_width_p (W),
        .len_width_p  (4),
        .len_pos_p    (8),
        .num_req_p    (N)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req_data_i       (req_data_i),
        .req_v_i          (req_v_i),
        .req_ready_and_o  (req_ready_and_o),
        .link_data_o      (link_data_o),
        .link_v_o         (link_v_o),
        .link_ready_and_i (link_ready_and_i),
        .grant_id_o       (grant_id_o),
        .locked_o         (locked_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] src [N][32];
    int           hd [N];
    int           tl [N];
    logic [W-1:0] lnk [$];
    int           lnk_cyc [$];
    int           gnt [$];
    int           cyc;
    int           acc_cyc0;
    int           bub;
    logic         bub_en = 1'b0;
    int           bub_link;
    logic         tail0_done;
    logic         r1_early;
    int           stall;
    int           stall_at = -1;
    int           stall_len = 0;
    logic         lock_ok;

    // Flit layout: req[31:24] pkt[23:16] idx[15:12] len[11:8].
    function automatic logic [W-1:0] flit(int r, int p, int i, int len);
        return {8'(r), 8'(p), 4'(i), 4'(len), 8'h00};
    endfunction

    task automatic push(int r, logic [W-1:0] f);
        src[r][tl[r]] = f;
        tl[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_v_i[r]    = (hd[r] != tl[r]) && !(r == 0 && bub > 0);
            req_data_i[r] = (hd[r] != tl[r]) ? src[r][hd[r]] : '0;
        end
        if (stall_at >= 0 && lnk.size() == stall_at && stall < stall_len) begin
            link_ready_and_i = 1'b0;
            stall++;
        end else begin
            link_ready_and_i = 1'b1;
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        logic [W-1:0] f;
        @(negedge clk);
        acc = req_v_i & req_ready_and_o;
        if (link_v_o && link_ready_and_i) begin
            lnk.push_back(link_data_o);
            lnk_cyc.push_back(cyc);
        end
        if (|acc) begin
            gnt.push_back(int'(grant_id_o));
            if (acc_cyc0 < 0) acc_cyc0 = cyc;
        end
        if (bub > 0 && link_v_o) bub_link++;
        if (bub_en && req_ready_and_o[1] && !tail0_done) r1_early = 1'b1;
        if (!link_ready_and_i) lock_ok &= locked_o;
        @(posedge clk);
        #1;
        cyc++;
        if (bub > 0) bub--;
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                f = src[r][hd[r]];
                hd[r]++;
                if (bub_en && r == 0 && f[15:12] == 4'd0) bub = 3;
                if (bub_en && r == 0 && f[15:12] == 4'd2) tail0_done = 1'b1;
            end
        end
        drive();
    endtask

    task automatic run_until(int n, int budget);
        int start;
        start = cyc;
        while (lnk.size() < n && cyc - start < budget) step();
        chk("timeout", 64'(lnk.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        reset_i          = 1'b1;
        req_v_i          = '0;
        req_data_i       = '0;
        link_ready_and_i = 1'b1;
        for (int r = 0; r < N; r++) begin
            hd[r] = 0;
            tl[r] = 0;
        end
        lnk.delete();
        lnk_cyc.delete();
        gnt.delete();
        acc_cyc0 = -1;
        bub      = 0;
        stall    = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        cyc     = 0;
        drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int cnt [N];
        logic [W-1:0] e;

        // Reset state while reset held, requester 0 valid.
        reset_i = 1'b1;
        req_v_i = 4'b0001;
        req_data_i = '0;
        link_ready_and_i = 1'b1;
        #12;
        chk("rst_link_v", 64'(link_v_o), 64'd0);
        chk("rst_ready", 64'(req_ready_and_o), 64'd0);
        chk("rst_grant", 64'(grant_id_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);

        // 1: back-to-back single-flit packets from requester 0.
        do_reset();
        for (int k = 0; k < 8; k++) push(0, flit(0, k, 0, 0));
        drive();
        run_until(8, 40);
        chk("t1_acc0", 64'(acc_cyc0), 64'd0);
        chk("t1_latency", 64'(lnk_cyc[0] - acc_cyc0), 64'd1);
        chk("t1_rate", 64'(lnk_cyc[7] - lnk_cyc[0]), 64'd7);
        chk("t1_first", 64'(lnk[0]), 64'(flit(0, 0, 0, 0)));
        chk("t1_last", 64'(lnk[7]), 64'(flit(0, 7, 0, 0)));

        // 2: two len=3 packets must not interleave.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                push(r, flit(r, 0, i, (i == 0) ? 3 : 0));
        drive();
        run_until(8, 60);
        for (int i = 0; i < 8; i++) begin
            e = flit(i / 4, 0, i % 4, (i % 4 == 0) ? 3 : 0);
            chk("t2_flit", 64'(lnk[i]), 64'(e));
        end

        // 3: all requesters busy with single-flit packets.
        do_reset();
        for (int k = 0; k < 8; k++)
            for (int r = 0; r < N; r++)
                push(r, flit(r, k, 0, 0));
        drive();
        run_until(32, 100);
        for (int i = 0; i < 8; i++)
            chk("t3_grant", 64'(gnt[i]), 64'(i % 4));
        for (int r = 0; r < N; r++) cnt[r] = 0;
        for (int i = 0; i < 16; i++) cnt[int'(lnk[i][31:24])]++;
        for (int r = 0; r < N; r++)
            chk("t3_share", 64'(cnt[r]), 64'd4);

        // 4: len=5 packet with link stalled after 2 flits.
        do_reset();
        stall_at  = 2;
        stall_len = 5;
        lock_ok   = 1'b1;
        for (int i = 0; i < 6; i++) push(0, flit(0, 0, i, (i == 0) ? 5 : 0));
        drive();
        run_until(6, 40);
        for (int i = 0; i < 6; i++)
            chk("t4_flit", 64'(lnk[i]), 64'(flit(0, 0, i, (i == 0) ? 5 : 0)));
        chk("t4_stalled", 64'(stall), 64'd5);
        chk("t4_locked", 64'(lock_ok), 64'd1);
        repeat (4) step();
        chk("t4_nodup", 64'(lnk.size()), 64'd6);
        stall_at = -1;

        // 5: locked requester bubbles while requester 1 waits.
        do_reset();
        bub_en     = 1'b1;
        tail0_done = 1'b0;
        r1_early   = 1'b0;
        bub_link   = 0;
        for (int i = 0; i < 3; i++) push(0, flit(0, 0, i, (i == 0) ? 2 : 0));
        push(1, flit(1, 0, 0, 0));
        drive();
        run_until(4, 40);
        for (int i = 0; i < 3; i++)
            chk("t5_r0", 64'(lnk[i]), 64'(flit(0, 0, i, (i == 0) ? 2 : 0)));
        chk("t5_r1", 64'(lnk[3]), 64'(flit(1, 0, 0, 0)));
        chk("t5_r1_stall", 64'(r1_early), 64'd0);
        chk("t5_idle", 64'(bub_link), 64'd1);
        chk("t5_grant", 64'(gnt[3]), 64'd1);
        bub_en = 1'b0;

        // 6: asynchronous reset in the middle of a packet.
        do_reset();
        for (int i = 0; i < 6; i++) push(0, flit(0, 1, i, (i == 0) ? 5 : 0));
        drive();
        repeat (3) step();
        chk("t6_pre_v", 64'(link_v_o), 64'd1);
        chk("t6_pre_lock", 64'(locked_o), 64'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t6_async_v", 64'(link_v_o), 64'd0);
        chk("t6_async_lock", 64'(locked_o), 64'd0);
        chk("t6_async_rdy", 64'(req_ready_and_o), 64'd0);
        do_reset();
        #1;
        chk("t6_grant0", 64'(grant_id_o), 64'd0);
        chk("t6_lock0", 64'(locked_o), 64'd0);
        push(2, flit(2, 0, 0, 0));
        drive();
        #1;
        chk("t6_grant2", 64'(grant_id_o), 64'd2);
        run_until(1, 10);
        chk("t6_flit", 64'(lnk[0]), 64'(flit(2, 0, 0, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
